// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the serializer state encoding.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQEN = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer. The head is visible on dout with no
// read latency; flush empties it and overrides any same-cycle push or pop.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // Full/empty are judged on the pre-edge count, so a push into a full FIFO
  // is dropped even when a pop happens on the same edge.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter responding on a CPU memory bank:
// register file, TX FIFO and bit serializer with a programmable baud divider.
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  memWrite,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    sel;
  logic          wr_en, rd_en;
  logic          push, flush, pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    count4;
  logic          busy, can_start, bit_end;
  logic          unused_bits;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_div_q, baud_div_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;

  assign sel         = addr[1:0];
  assign wr_en       = en & (|memWrite);
  assign rd_en       = en & ~(|memWrite);
  assign push        = wr_en & (sel == REG_TXDATA) & memWrite[0];
  assign flush       = wr_en & (sel == REG_CTRL) & memWrite[0] & wdata[CTRL_FLUSH];
  assign count4      = 4'(fifo_count);
  assign busy        = (state_q != S_IDLE);
  assign irq         = irq_en_q & fifo_empty & ~busy;
  assign txd         = txd_q;
  assign unused_bits = ^{addr[10:2], wdata[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A flush on this edge cancels the pop, so no new frame may start with it.
  assign can_start = tx_en_q & ~fifo_empty & ~flush;
  assign bit_end   = (baud_cnt_q == bit_div_q);

  always_comb begin
    baud_div_d = baud_div_q;
    tx_en_d    = tx_en_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    state_d    = state_q;
    bit_div_d  = bit_div_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    if (wr_en && sel == REG_STATUS && memWrite[0] && wdata[ST_OVF]) ovf_d = 1'b0;
    if (push && fifo_full) ovf_d = 1'b1;

    if (wr_en && sel == REG_BAUDDIV) begin
      if (memWrite[0]) baud_div_d[7:0]  = wdata[7:0];
      if (memWrite[1]) baud_div_d[15:8] = wdata[15:8];
    end
    if (wr_en && sel == REG_CTRL && memWrite[0]) begin
      tx_en_d  = wdata[CTRL_TXEN];
      irq_en_d = wdata[CTRL_IRQEN];
    end

    // Every bit boundary latches the divisor, so a BAUDDIV write only
    // affects bits that start after it.
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop        = 1'b1;
          state_d    = S_START;
          txd_d      = 1'b0;
          shift_d    = fifo_dout;
          baud_cnt_d = '0;
          bit_div_d  = baud_div_q;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d    = S_DATA;
          bit_idx_d  = '0;
          txd_d      = shift_q[0];
          baud_cnt_d = '0;
          bit_div_d  = baud_div_q;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_div_d  = baud_div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (can_start) begin
            pop        = 1'b1;
            state_d    = S_START;
            txd_d      = 1'b0;
            shift_d    = fifo_dout;
            baud_cnt_d = '0;
            bit_div_d  = baud_div_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_div_q <= DEFAULT_DIV;
      bit_div_q  <= DEFAULT_DIV;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_div_q <= baud_div_d;
      bit_div_q  <= bit_div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (sel)
        REG_STATUS: begin
          rdata[ST_FULL]          = fifo_full;
          rdata[ST_EMPTY]         = fifo_empty;
          rdata[ST_BUSY]          = busy;
          rdata[ST_OVF]           = ovf_q;
          rdata[ST_COUNT +: 4]    = count4;
        end
        REG_BAUDDIV: rdata[15:0] = baud_div_q;
        REG_CTRL: begin
          rdata[CTRL_TXEN]  = tx_en_q;
          rdata[CTRL_IRQEN] = irq_en_q;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule
